// File: rtl/lattic_scan_if.sv
// lattic_scan_if: frame data, control and LED drive bundle for the
// lattic_scan matrix scanner. master = frame source / LED sink,
// slave = the scanner itself.
interface lattic_scan_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) ();
    logic [ROWS*COLS-1:0] r_dis;
    logic [ROWS*COLS-1:0] g_dis;
    logic                 load;
    logic                 enable;
    logic [3:0]           brightness;
    logic [ROWS-1:0]      row;
    logic [COLS-1:0]      r_col;
    logic [COLS-1:0]      g_col;
    logic                 frame_start;

    modport master (
        output r_dis, g_dis, load, enable, brightness,
        input  row, r_col, g_col, frame_start
    );

    modport slave (
        input  r_dis, g_dis, load, enable, brightness,
        output row, r_col, g_col, frame_start
    );
endinterface

// File: rtl/lattic_scan.sv
// lattic_scan: row-multiplexed bicolour LED matrix scanner.
// Each row slot is ROW_TICKS cycles: BLANK_TICKS of blanking, then drive.
// Frame data is double-buffered; a load request is adopted only at the
// frame boundary (row wrap to 0) so a frame is never torn.
// Optional macro LATTIC_SCAN_PWM_EN adds 4-bit global PWM dimming driven by
// the brightness input (latched per frame); without it brightness is ignored.
module lattic_scan #(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int ROW_TICKS   = 50000,
    parameter int BLANK_TICKS = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    lattic_scan_if.slave  bus
);
    localparam int TW = (ROW_TICKS > 1) ? $clog2(ROW_TICKS) : 1;
    localparam int RW = $clog2(ROWS);

    typedef enum logic {S_BLANK, S_DRIVE} state_t;

    localparam state_t RST_STATE = (BLANK_TICKS == 0) ? S_DRIVE : S_BLANK;

    logic [TW-1:0]        r_tick;
    logic [RW-1:0]        r_row_idx;
    logic                 r_pending;
    logic [ROWS*COLS-1:0] r_r_shadow;
    logic [ROWS*COLS-1:0] r_g_shadow;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [TW-1:0]        w_tick_nxt;
    logic                 w_tick_last;
    logic                 w_row_last;
    logic                 w_wrap;
    logic                 w_lit;

    logic [ROWS-1:0]      r_row;
    logic [COLS-1:0]      r_rcol;
    logic [COLS-1:0]      r_gcol;
    logic                 r_fs;
    logic [ROWS-1:0]      w_row_nxt;
    logic [COLS-1:0]      w_rcol_nxt;
    logic [COLS-1:0]      w_gcol_nxt;
    logic                 w_fs_nxt;

    assign w_tick_last = (r_tick == TW'(ROW_TICKS - 1));
    assign w_row_last  = (r_row_idx == RW'(ROWS - 1));
    assign w_wrap      = w_tick_last && w_row_last;
    assign w_tick_nxt  = w_tick_last ? '0 : r_tick + 1'b1;

    // Slot tick and row index counters; row advances when the tick wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick    <= '0;
            r_row_idx <= '0;
        end else begin
            r_tick <= w_tick_nxt;
            if (w_tick_last)
                r_row_idx <= w_row_last ? '0 : r_row_idx + 1'b1;
        end
    end

    // Phase FSM state register; tracks whether the current tick is blanking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RST_STATE;
        else        r_state <= w_state_nxt;
    end

    // Phase FSM next state: BLANK for the first BLANK_TICKS of a slot.
    always_comb begin
        w_state_nxt = S_DRIVE;
        if ((BLANK_TICKS != 0) && (int'(w_tick_nxt) < BLANK_TICKS))
            w_state_nxt = S_BLANK;
    end

    // Load request is held pending and adopted only at the frame wrap; a
    // request arriving on the wrap cycle itself is taken at that wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= 1'b0;
            r_r_shadow <= '0;
            r_g_shadow <= '0;
        end else if (w_wrap && (r_pending || bus.load)) begin
            r_pending  <= 1'b0;
            r_r_shadow <= bus.r_dis;
            r_g_shadow <= bus.g_dis;
        end else if (bus.load) begin
            r_pending <= 1'b1;
        end
    end

`ifdef LATTIC_SCAN_PWM_EN
    logic [3:0] r_pwm;
    logic [3:0] r_bright;

    // Free-running duty counter and per-frame brightness latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm    <= '0;
            r_bright <= '0;
        end else begin
            r_pwm <= r_pwm + 1'b1;
            if (w_wrap) r_bright <= bus.brightness;
        end
    end

    assign w_lit = (r_pwm < r_bright);
`else
    logic w_unused_bright;
    assign w_unused_bright = ^bus.brightness;
    assign w_lit           = 1'b1;
`endif

    // Next drive values from current state; blank unless enabled and driving.
    always_comb begin
        w_row_nxt  = '0;
        w_rcol_nxt = '1;
        w_gcol_nxt = '1;
        w_fs_nxt   = (r_tick == '0) && (r_row_idx == '0);
        if (bus.enable && (r_state == S_DRIVE)) begin
            w_row_nxt = ROWS'(1) << r_row_idx;
            if (w_lit) begin
                w_rcol_nxt = ~r_r_shadow[int'(r_row_idx)*COLS +: COLS];
                w_gcol_nxt = ~r_g_shadow[int'(r_row_idx)*COLS +: COLS];
            end
        end
    end

    // Output registers: everything seen at the pins lags state by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row  <= '0;
            r_rcol <= '1;
            r_gcol <= '1;
            r_fs   <= 1'b0;
        end else begin
            r_row  <= w_row_nxt;
            r_rcol <= w_rcol_nxt;
            r_gcol <= w_gcol_nxt;
            r_fs   <= w_fs_nxt;
        end
    end

    assign bus.row         = r_row;
    assign bus.r_col       = r_rcol;
    assign bus.g_col       = r_gcol;
    assign bus.frame_start = r_fs;
endmodule

// File: tb/tb_lattic_scan.sv
// tb_lattic_scan: self-checking bench for lattic_scan (ROWS=4, COLS=4,
// ROW_TICKS=10, BLANK_TICKS=2). A frame-level reference model derives the
// expected pins from the cycle count since reset; a vector table and short
// directed sequences cover the frame-boundary corner cases.
module tb_lattic_scan;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int RT   = 10;
    localparam int BT   = 2;
    localparam int FR   = ROWS * RT;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lattic_scan_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    lattic_scan #(
        .ROWS(ROWS), .COLS(COLS), .ROW_TICKS(RT), .BLANK_TICKS(BT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: cycles since reset, pending load, shown frame.
    int          n;
    bit          pend;
    logic [15:0] sh_r, sh_g;
    logic [3:0]  blat;

    typedef struct {
        int         rk;
        int         tk;
        logic [3:0] e_row;
        logic [3:0] e_r;
        logic [3:0] e_g;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: predict the pins from the model, clock, update, compare.
    task automatic step();
        int ph, tk, ri;
        bit lit, ld;
        logic [3:0] erow, er, eg;
        logic [15:0] dr, dg;
        logic [3:0] br;
        ph = n % FR;
        tk = ph % RT;
        ri = ph / RT;
        ld = bus.load;
        dr = bus.r_dis;
        dg = bus.g_dis;
        br = bus.brightness;
        lit  = bus.enable && (tk >= BT);
        erow = lit ? 4'(1 << ri) : 4'h0;
`ifdef LATTIC_SCAN_PWM_EN
        lit = lit && ((n % 16) < int'(blat));
`endif
        er = lit ? ~sh_r[ri*COLS +: COLS] : 4'hF;
        eg = lit ? ~sh_g[ri*COLS +: COLS] : 4'hF;
        @(posedge clk);
        if (ph == FR - 1) begin
            if (pend || ld) begin
                sh_r = dr;
                sh_g = dg;
                pend = 1'b0;
            end
            blat = br;
        end else if (ld) begin
            pend = 1'b1;
        end
        if (ph == FR - 1 && !(pend) && ld) pend = 1'b0;
        n++;
        #1;
        check("row",         bus.row,         erow);
        check("r_col",       bus.r_col,       er);
        check("g_col",       bus.g_col,       eg);
        check("frame_start", bus.frame_start, (ph == 0));
    endtask

    // Reset must blank the pins immediately, without waiting for a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_row",   bus.row,         4'h0);
        check("rst_r_col", bus.r_col,       4'hF);
        check("rst_g_col", bus.g_col,       4'hF);
        check("rst_fs",    bus.frame_start, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n    = 0;
        pend = 1'b0;
        sh_r = '0;
        sh_g = '0;
        blat = '0;
    endtask

    // Advance until the model is about to clock the given row/tick.
    task automatic run_to(input int rk, input int tk);
        for (int i = 0; i < 2 * FR && (n % FR) != rk * RT + tk; i++) step();
    endtask

    initial begin
        vt[0] = '{0, 5, 4'h1, 4'hE, 4'h3};
        vt[1] = '{1, 2, 4'h2, 4'hD, 4'hC};
        vt[2] = '{1, 5, 4'h2, 4'hD, 4'hC};
        vt[3] = '{2, 0, 4'h0, 4'hF, 4'hF};
        vt[4] = '{2, 5, 4'h4, 4'hB, 4'h0};
        vt[5] = '{3, 1, 4'h0, 4'hF, 4'hF};
        vt[6] = '{3, 5, 4'h8, 4'h7, 4'hF};
        vt[7] = '{3, 9, 4'h8, 4'h7, 4'hF};

        bus.r_dis      = '0;
        bus.g_dis      = '0;
        bus.load       = 1'b0;
        bus.enable     = 1'b1;
        bus.brightness = 4'hF;
        n = 0; pend = 1'b0; sh_r = '0; sh_g = '0; blat = '0;
        #2;
        do_reset();

        // Single load after reset; shown from the first wrap onward.
        bus.r_dis = 16'h8421;
        bus.g_dis = 16'h0F3C;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
        run_to(3, 9);
        step();
`ifndef LATTIC_SCAN_PWM_EN
        for (int i = 0; i < 8; i++) begin
            run_to(vt[i].rk, vt[i].tk);
            step();
            check($sformatf("vec%0d_row", i),   bus.row,   vt[i].e_row);
            check($sformatf("vec%0d_r_col", i), bus.r_col, vt[i].e_r);
            check($sformatf("vec%0d_g_col", i), bus.g_col, vt[i].e_g);
        end
`endif

        // Load mid-frame: no tearing, adopted at the next row 0.
        run_to(2, 3);
        bus.r_dis = 16'h1248;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
        run_to(3, 5);
        step();
`ifndef LATTIC_SCAN_PWM_EN
        check("no_tear_row3", bus.r_col, 4'h7);
`endif
        run_to(0, 5);
        step();
`ifndef LATTIC_SCAN_PWM_EN
        check("new_frame_row0", bus.r_col, 4'h7);
`endif

        // Load asserted on the wrap cycle is taken at that same wrap.
        run_to(3, 9);
        bus.r_dis = 16'h2222;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
        run_to(1, 5);
        step();
`ifndef LATTIC_SCAN_PWM_EN
        check("wrap_load_row1", bus.r_col, 4'hD);
`endif

        // Enable drop at tick 5 of row 1, then resume with no phase slip.
        run_to(1, 5);
        bus.enable = 1'b0;
        step();
        check("disable_row", bus.row, 4'h0);
        repeat (2) step();
        bus.enable = 1'b1;
        run_to(1, 9);
        step();
        check("resume_row", bus.row, 4'h2);

        // Reset pulsed mid row 2; restart at row 0 with an empty frame.
        run_to(2, 4);
        do_reset();
        repeat (FR + 5) step();

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 800; i++) begin
            bus.r_dis      = 16'($urandom);
            bus.g_dis      = 16'($urandom);
            bus.load       = ($urandom_range(0, 15) == 0);
            bus.enable     = ($urandom_range(0, 7) != 0);
            bus.brightness = 4'($urandom_range(0, 15));
            step();
        end
        bus.load = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lattic_scan.md
LATTIC_SCAN -- requirements
Module: lattic_scan

Interface
REQ-001 Parameter ROWS, default 8, number of matrix rows (2..16).
REQ-002 Parameter COLS, default 8, number of columns per colour (1..32).
REQ-003 Parameter ROW_TICKS, default 50000, clock cycles per row slot; must exceed BLANK_TICKS.
REQ-004 Parameter BLANK_TICKS, default 16, blanking cycles at the start of each row slot (0 allowed).
REQ-005 Port clk  in  1  system clock; all logic on the rising edge.
REQ-006 Port rst_n  in  1  asynchronous, active-low reset.
REQ-007 Port r_dis  in  ROWS*COLS  red frame data; row k occupies bits [k*COLS +: COLS]; 1 = LED lit.
REQ-008 Port g_dis  in  ROWS*COLS  green frame data, same mapping as r_dis.
REQ-009 Port load  in  1  single-cycle request to adopt r_dis/g_dis at the next frame boundary.
REQ-010 Port enable  in  1  1 = scan drives LEDs; 0 = outputs forced blank.
REQ-011 Port brightness  in  4  global dimming level (see Configuration).
REQ-012 Port row  out  ROWS  one-hot row select, active-high.
REQ-013 Port r_col  out  COLS  red column drive, active-low.
REQ-014 Port g_col  out  COLS  green column drive, active-low.
REQ-015 Port frame_start  out  1  one-cycle pulse when row 0 slot begins.

Function
REQ-016 Tick counter SHALL count 0..ROW_TICKS-1 and wrap, advancing row_idx on wrap; row_idx SHALL wrap from ROWS-1 to 0.
REQ-017 FSM states: BLANK (tick < BLANK_TICKS) and DRIVE (otherwise); BLANK_TICKS=0 SHALL skip BLANK entirely.
REQ-018 In BLANK, row SHALL be all 0 and r_col/g_col all 1.
REQ-019 In DRIVE, row SHALL have only bit row_idx set; r_col SHALL be ~r_shadow[row_idx*COLS +: COLS]; g_col likewise from g_shadow.
REQ-020 All outputs SHALL be registered, lagging internal state by exactly one clock.
REQ-021 load SHALL set a pending flag; on the row_idx wrap to 0, pending SHALL copy r_dis/g_dis into shadow registers and clear itself.
REQ-022 load coincident with the wrap cycle SHALL be captured at that same wrap.
REQ-023 Shadow registers SHALL NOT change mid-frame (no tearing).
REQ-024 frame_start SHALL pulse for one cycle, aligned with the first output cycle of the row 0 slot.
REQ-025 enable=0 SHALL force BLANK outputs on the next cycle; counters, frame_start and load handling continue unaffected.

Reset
REQ-026 On rst_n low: tick=0, row_idx=0, pending=0, shadows=0, row=0, r_col=g_col=all 1, frame_start=0.
REQ-027 Reset SHALL take effect immediately mid-frame; after release scanning restarts at row 0 in BLANK.

Configuration
REQ-028 Macro LATTIC_SCAN_PWM_EN defined: a free-running 4-bit pwm counter is added; in DRIVE, columns are lit only while pwm < brightness_latched; brightness is latched at each frame boundary; brightness 0 = dark, 15 = 15/16 duty.
REQ-029 Macro undefined: brightness port exists but is ignored; DRIVE columns are lit at 100% duty.

Verification (ROWS=4, COLS=4, ROW_TICKS=10, BLANK_TICKS=2)
REQ-030 Reset, load=1 once with r_dis=16'h8421, enable=1 -> after first wrap, rows 0..3 drive r_col=4'hE,D,B,7 during ticks 2..9, blank during ticks 0..1.
REQ-031 Free run -> row sequence 0001,0010,0100,1000,0001; frame_start every 40 cycles.
REQ-032 load with new data in row 2 slot -> displayed data unchanged until the next row 0; load on the wrap cycle -> captured that frame.
REQ-033 enable dropped at tick 5 of row 1 -> blank next cycle; re-enable -> resumes at the current row with no phase slip.
REQ-034 rst_n pulsed mid-row 2 -> outputs immediately blank, shadow 0; restart at row 0.
REQ-035 With LATTIC_SCAN_PWM_EN, brightness=4 -> lit 4 of every 16 DRIVE cycles; brightness=0 -> never lit; brightness change mid-frame takes effect at the next frame.
